fc_argmax_classifier: RTL and testbench

- Final stage of the LeNet accelerator; sits directly downstream of the fully connected layer.
- Captures the 10-entry class-score vector with a valid/ready handshake.
- Scans the captured scores sequentially, one comparator per cycle, and emits the winning class index and its score.
- Result is held until the consumer (host/readout) accepts it.

---
 rtl/fc_argmax_classifier.sv | 159 +++++++++++++++
 tb/tb_fc_argmax_classifier.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_argmax_classifier.sv
// fc_argmax_classifier: final LeNet stage. Captures a vector of signed class scores over a
// valid/ready handshake, scans it one comparison per cycle and holds the winning class index
// and score until the consumer accepts them.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     score vector on scores is valid
//   in_ready     block can accept a vector (IDLE only)
//   scores       unpacked array of NUM_CLASSES signed scores
//   out_valid    result valid, held until out_ready
//   out_ready    consumer accepts the result
//   class_idx    index of the maximum score (lowest index on ties)
//   class_score  value of the maximum score
//   class_margin best minus second-best score (only with ARGMAX_MARGIN_EN defined)
//
// Optional feature: define ARGMAX_MARGIN_EN to add second-best tracking and class_margin.

module fc_argmax_classifier #(
  parameter int unsigned bitwidth    = 32,
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned IDXW        = $clog2(NUM_CLASSES)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [bitwidth-1:0] scores [NUM_CLASSES],
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [IDXW-1:0]            class_idx,
  output logic signed [bitwidth-1:0] class_score
`ifdef ARGMAX_MARGIN_EN
  ,
  output logic signed [bitwidth:0]   class_margin
`endif
);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  localparam logic [IDXW-1:0] LastIdx = IDXW'(NUM_CLASSES - 1);

  state_e                     state_q;
  logic signed [bitwidth-1:0] buf_q [NUM_CLASSES];
  logic [IDXW-1:0]            idx_q;
  logic [IDXW-1:0]            best_idx_q, best_idx_d;
  logic signed [bitwidth-1:0] best_val_q, best_val_d;
  logic signed [bitwidth-1:0] cand;
  logic                       cand_gt_best;
  logic                       in_ready_q;
  logic                       out_valid_q;
  logic [IDXW-1:0]            class_idx_q;
  logic signed [bitwidth-1:0] class_score_q;

  // Strictly-greater replacement keeps the lowest index on ties.
  always_comb begin
    cand         = buf_q[idx_q];
    cand_gt_best = cand > best_val_q;
    best_val_d   = cand_gt_best ? cand : best_val_q;
    best_idx_d   = cand_gt_best ? idx_q : best_idx_q;
  end

`ifdef ARGMAX_MARGIN_EN
  // Second-best starts at the most negative value so index 1 always seeds it.
  localparam logic signed [bitwidth-1:0] MinVal = {1'b1, {(bitwidth - 1){1'b0}}};

  logic signed [bitwidth-1:0] second_q, second_d;
  logic signed [bitwidth:0]   margin_d;
  logic signed [bitwidth:0]   class_margin_q;

  always_comb begin
    if (cand_gt_best) begin
      second_d = best_val_q;
    end else if (cand > second_q) begin
      second_d = cand;
    end else begin
      second_d = second_q;
    end
    // One extra bit so best - second never overflows.
    margin_d = {best_val_d[bitwidth-1], best_val_d} - {second_d[bitwidth-1], second_d};
  end

  assign class_margin = class_margin_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      class_idx_q   <= '0;
      class_score_q <= '0;
      idx_q         <= '0;
      best_idx_q    <= '0;
      best_val_q    <= '0;
      for (int unsigned i = 0; i < NUM_CLASSES; i++) begin
        buf_q[i] <= '0;
      end
`ifdef ARGMAX_MARGIN_EN
      second_q       <= '0;
      class_margin_q <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid && in_ready_q) begin
            for (int unsigned i = 0; i < NUM_CLASSES; i++) begin
              buf_q[i] <= scores[i];
            end
            best_val_q <= scores[0];
            best_idx_q <= '0;
            idx_q      <= IDXW'(1);
            in_ready_q <= 1'b0;
`ifdef ARGMAX_MARGIN_EN
            second_q   <= MinVal;
`endif
            state_q    <= StScan;
          end
        end
        StScan: begin
          best_val_q <= best_val_d;
          best_idx_q <= best_idx_d;
`ifdef ARGMAX_MARGIN_EN
          second_q   <= second_d;
`endif
          if (idx_q == LastIdx) begin
            idx_q         <= '0;
            out_valid_q   <= 1'b1;
            class_idx_q   <= best_idx_d;
            class_score_q <= best_val_d;
`ifdef ARGMAX_MARGIN_EN
            class_margin_q <= margin_d;
`endif
            state_q       <= StDone;
          end else begin
            idx_q <= idx_q + IDXW'(1);
          end
        end
        StDone: begin
          // in_ready rises with the return to IDLE, one cycle after the output handshake.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign class_idx   = class_idx_q;
  assign class_score = class_score_q;

endmodule

// File: tb/tb_fc_argmax_classifier.sv
// Self-checking bench for fc_argmax_classifier: directed vectors, backpressure, reset during
// scan, ignored input while busy, randomized vectors and back-to-back throughput, all checked
// against a plain argmax reference model.

module tb_fc_argmax_classifier;

  localparam int NC = 10;

  typedef logic signed [31:0] vec_t [NC];

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  vec_t               scores;
  logic               out_valid;
  logic               out_ready;
  logic [3:0]         class_idx;
  logic signed [31:0] class_score;
`ifdef ARGMAX_MARGIN_EN
  logic signed [32:0] class_margin;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fc_argmax_classifier dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .scores      (scores),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .class_idx   (class_idx),
    .class_score (class_score)
`ifdef ARGMAX_MARGIN_EN
    ,
    .class_margin(class_margin)
`endif
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: first index of the maximum, margin against the max of all other entries.
  function automatic void ref_argmax(input vec_t v, output int idx, output longint best,
                                     output longint margin);
    longint second;
    bit     have;
    idx = 0;
    for (int i = 1; i < NC; i++) begin
      if (v[i] > v[idx]) idx = i;
    end
    best   = longint'(v[idx]);
    have   = 1'b0;
    second = 0;
    for (int i = 0; i < NC; i++) begin
      if (i != idx && (!have || longint'(v[i]) > second)) begin
        second = longint'(v[i]);
        have   = 1'b1;
      end
    end
    margin = best - second;
  endfunction

  task automatic rand_vec(output vec_t v);
    int mode;
    mode = int'($urandom_range(0, 2));
    for (int i = 0; i < NC; i++) begin
      case (mode)
        0: v[i] = $urandom;
        1: v[i] = int'($urandom_range(0, 8)) - 4;
        default: begin
          if ($urandom_range(0, 3) == 0) v[i] = ($urandom_range(0, 1) == 1) ? 32'h80000000
                                                                         : 32'h7FFFFFFF;
          else v[i] = $urandom;
        end
      endcase
    end
  endtask

  // Starts and ends one time unit after a rising edge; DUT must be idle on entry.
  // lat = edges from accept to out_valid, or -1 if it never rose.
  task automatic send(input vec_t v, input bit hold, output int lat);
    vec_t junk;
    scores   = v;
    in_valid = 1'b1;
    @(posedge clk); #1;
    if (!hold) in_valid = 1'b0;
    lat = -1;
    for (int n = 1; n <= 30; n++) begin
      if (hold) begin
        rand_vec(junk);
        scores = junk;
      end
      @(posedge clk); #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < NC; i++) scores[i] = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (class_idx !== 4'd0) begin
      failures++; $display("FAIL reset_class_idx: got %0d expected 0", class_idx);
    end
    checks++;
    if (class_score !== 32'sd0) begin
      failures++; $display("FAIL reset_class_score: got %0d expected 0", class_score);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle: got in_ready=%b out_valid=%b expected 1/0", in_ready,
               out_valid);
    end
  endtask

  task automatic test_directed();
    vec_t v;
    int   lat;
    int   eidx[3] = '{7, 2, 1};
    int   esc[3]  = '{26, 50, -3};
    int   emg[3]  = '{17, 0, 0};
    for (int t = 0; t < 3; t++) begin
      case (t)
        0:       v = '{3, 1, 4, 1, 5, 9, 2, 26, 5, 3};
        1:       v = '{0, 0, 50, 0, 0, 50, 0, 0, 0, 0};
        default: v = '{-5, -3, -9, -3, -100, -7, -8, -4, -6, -10};
      endcase
      send(v, 1'b0, lat);
      checks++;
      if (lat != 9) begin
        failures++; $display("FAIL directed%0d_latency: got %0d expected 9", t, lat);
      end
      checks++;
      if (class_idx !== 4'(eidx[t])) begin
        failures++;
        $display("FAIL directed%0d_idx: got %0d expected %0d", t, class_idx, eidx[t]);
      end
      checks++;
      if (class_score !== 32'(esc[t])) begin
        failures++;
        $display("FAIL directed%0d_score: got %0d expected %0d", t, class_score, esc[t]);
      end
`ifdef ARGMAX_MARGIN_EN
      checks++;
      if (class_margin !== 33'(emg[t])) begin
        failures++;
        $display("FAIL directed%0d_margin: got %0d expected %0d", t, class_margin, emg[t]);
      end
`else
      if (emg[t] < 0) $display("note: unexpected negative margin constant");
`endif
      drain();
    end
  endtask

  task automatic test_backpressure();
    vec_t   v;
    int     lat, eidx;
    longint esc, emg;
    rand_vec(v);
    ref_argmax(v, eidx, esc, emg);
    send(v, 1'b0, lat);
    checks++;
    if (lat != 9) begin
      failures++; $display("FAIL bp_latency: got %0d expected 9", lat);
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold%0d_flags: got out_valid=%b in_ready=%b expected 1/0", k,
                 out_valid, in_ready);
      end
      checks++;
      if (class_idx !== 4'(eidx) || class_score !== 32'(esc)) begin
        failures++;
        $display("FAIL bp_hold%0d_result: got %0d/%0d expected %0d/%0d", k, class_idx,
                 class_score, eidx, esc);
      end
    end
    drain();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL bp_release_out_valid: got %b expected 0", out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_release_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_reset_mid_scan();
    vec_t v;
    int   lat;
    bit   seen;
    rand_vec(v);
    scores   = v;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || class_idx !== 4'd0 ||
        class_score !== 32'sd0) begin
      failures++;
      $display("FAIL midscan_reset_values: got ov=%b ir=%b idx=%0d score=%0d expected 0/1/0/0",
               out_valid, in_ready, class_idx, class_score);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL midscan_in_ready: got %b expected 1", in_ready);
    end
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++; $display("FAIL midscan_no_output: got out_valid seen=%b expected 0", seen);
    end
    for (int i = 0; i < NC; i++) v[i] = (i == 9) ? 32'sd1 : 32'sd0;
    send(v, 1'b0, lat);
    checks++;
    if (lat != 9 || class_idx !== 4'd9 || class_score !== 32'sd1) begin
      failures++;
      $display("FAIL midscan_new_vector: got lat=%0d idx=%0d score=%0d expected 9/9/1", lat,
               class_idx, class_score);
    end
`ifdef ARGMAX_MARGIN_EN
    checks++;
    if (class_margin !== 33'sd1) begin
      failures++; $display("FAIL midscan_margin: got %0d expected 1", class_margin);
    end
`endif
    drain();
  endtask

  task automatic test_ignore_busy();
    vec_t   v, junk;
    int     lat, eidx;
    longint esc, emg;
    for (int i = 0; i < NC; i++) v[i] = int'($urandom_range(0, 2000)) - 1000;
    v[0] = 32'h80000000;
    v[8] = 32'h7FFFFFFF;
    ref_argmax(v, eidx, esc, emg);
    send(v, 1'b1, lat);
    checks++;
    if (lat != 9 || class_idx !== 4'd8 || class_score !== 32'sh7FFFFFFF) begin
      failures++;
      $display("FAIL ignore_result: got lat=%0d idx=%0d score=%0h expected 9/8/7fffffff", lat,
               class_idx, class_score);
    end
`ifdef ARGMAX_MARGIN_EN
    checks++;
    if (class_margin !== 33'(emg)) begin
      failures++; $display("FAIL ignore_margin: got %0d expected %0d", class_margin, emg);
    end
`endif
    for (int k = 0; k < 3; k++) begin
      rand_vec(junk);
      scores = junk;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || class_idx !== 4'(eidx)) begin
        failures++;
        $display("FAIL ignore_done%0d: got ov=%b ir=%b idx=%0d expected 1/0/%0d", k,
                 out_valid, in_ready, class_idx, eidx);
      end
    end
    in_valid = 1'b0;
    drain();
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL ignore_no_capture: got ir=%b ov=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_random();
    vec_t   v;
    int     lat, eidx, wait_n;
    longint esc, emg;
    for (int t = 0; t < 25; t++) begin
      rand_vec(v);
      ref_argmax(v, eidx, esc, emg);
      send(v, 1'b0, lat);
      checks++;
      if (lat != 9 || class_idx !== 4'(eidx) || class_score !== 32'(esc)) begin
        failures++;
        $display("FAIL random%0d: got lat=%0d idx=%0d score=%0d expected 9/%0d/%0d", t, lat,
                 class_idx, class_score, eidx, esc);
      end
`ifdef ARGMAX_MARGIN_EN
      checks++;
      if (class_margin !== 33'(emg)) begin
        failures++;
        $display("FAIL random%0d_margin: got %0d expected %0d", t, class_margin, emg);
      end
`endif
      wait_n = int'($urandom_range(0, 3));
      repeat (wait_n) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1) begin
        failures++; $display("FAIL random%0d_held: got out_valid=%b expected 1", t, out_valid);
      end
      drain();
    end
  endtask

  task automatic test_back_to_back();
    vec_t   vv[4];
    int     eidx[4];
    longint esc[4], emg[4];
    int     accepted = 0;
    int     results  = 0;
    int     last_acc = 0;
    bit     will_acc;
    for (int k = 0; k < 4; k++) begin
      rand_vec(vv[k]);
      ref_argmax(vv[k], eidx[k], esc[k], emg[k]);
    end
    scores    = vv[0];
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 100 && results < 4; cyc++) begin
      if (out_valid) begin
        checks++;
        if (class_idx !== 4'(eidx[results]) || class_score !== 32'(esc[results])) begin
          failures++;
          $display("FAIL b2b%0d_result: got %0d/%0d expected %0d/%0d", results, class_idx,
                   class_score, eidx[results], esc[results]);
        end
`ifdef ARGMAX_MARGIN_EN
        checks++;
        if (class_margin !== 33'(emg[results])) begin
          failures++;
          $display("FAIL b2b%0d_margin: got %0d expected %0d", results, class_margin,
                   emg[results]);
        end
`endif
        results++;
      end
      will_acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (will_acc) begin
        if (accepted > 0) begin
          checks++;
          if (cyc - last_acc != NC + 1) begin
            failures++;
            $display("FAIL b2b_spacing: got %0d expected %0d", cyc - last_acc, NC + 1);
          end
        end
        last_acc = cyc;
        accepted++;
        if (accepted < 4) scores = vv[accepted];
        else in_valid = 1'b0;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (results != 4) begin
      failures++; $display("FAIL b2b_count: got %0d results expected 4", results);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_scan();
    test_ignore_busy();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
